// File: rtl/com_input_filter_if.sv
// rtl/com_input_filter_if.sv - command-input filter bus: raw lines in, debounced word and change strobe out
//
// Signals
//   iComRaw      16  raw command lines, asynchronous, active-high after opto
//   oCom         16  debounced command word
//   oChange       1  one-cycle strobe, at least one oCom bit changed
//   oChangeMask  16  bits that changed with the current oChange, 0 otherwise
// Modports
//   master  filter side (drives oCom/oChange/oChangeMask)
//   slave   line source / word consumer side (drives iComRaw)
interface com_input_filter_if;
    logic [15:0] iComRaw;
    logic [15:0] oCom;
    logic        oChange;
    logic [15:0] oChangeMask;

    modport master (
        input  iComRaw,
        output oCom,
        output oChange,
        output oChangeMask
    );

    modport slave (
        output iComRaw,
        input  oCom,
        input  oChange,
        input  oChangeMask
    );
endinterface

// File: rtl/com_input_filter.sv
// rtl/com_input_filter.sv - synchroniser and per-bit debouncer for the 16 discrete command inputs
//
// Ports
//   clk   in   system clock (2 MHz)
//   iRes  in   synchronous active-high reset
//   bus   com_input_filter_if.master: iComRaw in, oCom / oChange / oChangeMask out
// Parameters
//   SAMPLE_DIV  clk cycles per sample tick (>=1)
//   DEB_CNT     consecutive differing ticks needed to accept a new level (>=1)
//   HOLD_TICKS  minimum asserted time in ticks, used only with COM_FILTER_STRETCH_EN (>=1)
// Build option
//   COM_FILTER_STRETCH_EN  when defined, every accepted rise is held high for at least
//                          HOLD_TICKS ticks; a fall is deferred until the hold expires.
module com_input_filter #(
    parameter int SAMPLE_DIV = 200,
    parameter int DEB_CNT    = 10,
    parameter int HOLD_TICKS = 20
) (
    input  logic                  clk,
    input  logic                  iRes,
    com_input_filter_if.master    bus
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CNT - 1);

    logic [15:0]      sync1;
    logic [15:0]      sync2;
    logic [15:0]      com_q;
    logic [15:0]      com_next;
    logic             change_q;
    logic [15:0]      mask_q;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [DEB_W-1:0] deb_cnt  [16];
    logic [DEB_W-1:0] deb_next [16];

`ifdef COM_FILTER_STRETCH_EN
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
    logic [HOLD_W-1:0] hold_cnt  [16];
    logic [HOLD_W-1:0] hold_next [16];
`else
    logic unused_hold_ticks;
    assign unused_hold_ticks = (HOLD_TICKS != 0);
`endif

    // div_cnt idles at 0 out of reset, so the first edge after release is a tick.
    assign tick = (div_cnt == '0);

    always_comb begin
        com_next = com_q;
        for (int i = 0; i < 16; i++) begin
            deb_next[i] = deb_cnt[i];
`ifdef COM_FILTER_STRETCH_EN
            hold_next[i] = hold_cnt[i];
`endif
            if (tick) begin
`ifdef COM_FILTER_STRETCH_EN
                if (hold_cnt[i] != '0)
                    hold_next[i] = hold_cnt[i] - HOLD_W'(1);
`endif
                if (sync2[i] == com_q[i]) begin
                    // Input agrees with the output: any partial count was a glitch.
                    deb_next[i] = '0;
                end else if (deb_cnt[i] != DEB_LAST) begin
                    deb_next[i] = deb_cnt[i] + DEB_W'(1);
`ifdef COM_FILTER_STRETCH_EN
                end else if (com_q[i] && (hold_cnt[i] != '0)) begin
                    // Fall qualified but still inside the hold window: park at the
                    // saturated count so the fall lands on the first tick after expiry.
                    deb_next[i] = DEB_LAST;
`endif
                end else begin
                    com_next[i] = sync2[i];
                    deb_next[i] = '0;
`ifdef COM_FILTER_STRETCH_EN
                    if (sync2[i])
                        hold_next[i] = HOLD_LOAD;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iRes) begin
            sync1    <= '0;
            sync2    <= '0;
            com_q    <= '0;
            change_q <= 1'b0;
            mask_q   <= '0;
            div_cnt  <= '0;
            for (int i = 0; i < 16; i++) begin
                deb_cnt[i] <= '0;
`ifdef COM_FILTER_STRETCH_EN
                hold_cnt[i] <= '0;
`endif
            end
        end else begin
            sync1    <= bus.iComRaw;
            sync2    <= sync1;
            com_q    <= com_next;
            change_q <= |(com_next ^ com_q);
            mask_q   <= com_next ^ com_q;
            div_cnt  <= tick ? DIV_RELOAD : (div_cnt - DIV_W'(1));
            for (int i = 0; i < 16; i++) begin
                deb_cnt[i] <= deb_next[i];
`ifdef COM_FILTER_STRETCH_EN
                hold_cnt[i] <= hold_next[i];
`endif
            end
        end
    end

    assign bus.oCom        = com_q;
    assign bus.oChange     = change_q;
    assign bus.oChangeMask = mask_q;
endmodule

// File: tb/tb_com_input_filter.sv
// tb/tb_com_input_filter.sv - scoreboard bench for com_input_filter (SAMPLE_DIV=4, DEB_CNT=3, HOLD_TICKS=5)
module tb_com_input_filter;
    localparam int SD = 4;
    localparam int DC = 3;
    localparam int HT = 5;

    typedef struct {
        int          at_edge;
        logic [15:0] com;
        logic [15:0] mask;
    } exp_t;

    logic clk;
    logic iRes;
    com_input_filter_if bus();

    exp_t q[$];
    int   edge_no = 0;
    int   rel     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    com_input_filter #(
        .SAMPLE_DIV (SD),
        .DEB_CNT    (DC),
        .HOLD_TICKS (HT)
    ) dut (
        .clk  (clk),
        .iRes (iRes),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    endfunction

    // Edge at which a level first sampled into sync1 at edge e is accepted:
    // two sync stages, wait for the next tick, then DC ticks in total.
    function automatic int acc_edge(int e);
        int t;
        t = e + 2;
        while (((t - rel) % SD) != 0) t++;
        return t + (DC - 1) * SD;
    endfunction

    function automatic void push(int at, logic [15:0] com, logic [15:0] mask);
        exp_t x;
        x.at_edge = at;
        x.com     = com;
        x.mask    = mask;
        q.push_back(x);
    endfunction

    // Monitor: every strobe must match the head of the scoreboard; idle cycles carry no mask.
    always @(negedge clk) begin
        exp_t x;
        if (bus.oChange === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got oChange=1 mask=%0h oCom=%0h expected no strobe (edge %0d)",
                         bus.oChangeMask, bus.oCom, edge_no);
            end else begin
                x = q.pop_front();
                chk("strobe_edge", edge_no, x.at_edge);
                chk("strobe_com", {16'h0, bus.oCom}, {16'h0, x.com});
                chk("strobe_mask", {16'h0, bus.oChangeMask}, {16'h0, x.mask});
            end
        end else begin
            chk("idle_mask", {16'h0, bus.oChangeMask}, 32'h0);
        end
    end

    task automatic drain(string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic do_reset(logic [15:0] raw);
        bus.iComRaw = raw;
        iRes = 1'b1;
        @(negedge clk);
        iRes = 1'b0;
        rel = edge_no + 1;
    endtask

    initial begin
        int e;
        int a;
        iRes = 1'b1;
        bus.iComRaw = 16'hFFFF;

        // 1: reset holds outputs low even with all inputs high
        repeat (3) begin
            @(negedge clk);
            chk("reset_com", {16'h0, bus.oCom}, 32'h0);
            chk("reset_change", {31'h0, bus.oChange}, 32'h0);
        end

        // 2: step, accepted on the third tick after release (edge 12)
        iRes = 1'b0;
        rel = edge_no + 1;
        push(rel + 12, 16'hFFFF, 16'hFFFF);
        drain("step_drain");
        @(negedge clk);
        chk("step_hold_com", {16'h0, bus.oCom}, 32'h0000FFFF);

        // 3: 6-cycle glitch on bit 5 spans two ticks only
        do_reset(16'h0000);
        repeat (2) @(negedge clk);
        bus.iComRaw = 16'h0020;
        repeat (6) @(negedge clk);
        bus.iComRaw = 16'h0000;
        repeat (30) @(negedge clk);
        chk("glitch_com", {16'h0, bus.oCom}, 32'h0);

        // 4: simultaneous rise of bits 0 and 15, then a lone fall of bit 0
        do_reset(16'h0000);
        @(negedge clk);
        bus.iComRaw = 16'h8001;
        e = edge_no + 1;
        a = acc_edge(e);
        push(a, 16'h8001, 16'h8001);
        drain("multi_rise_drain");
        repeat (30) @(negedge clk);
        bus.iComRaw = 16'h8000;
        e = edge_no + 1;
        push(acc_edge(e), 16'h8000, 16'h0001);
        drain("multi_fall_drain");

        // 5: reset pulse while oCom=00F0 and bit 1 is partway through its count
        do_reset(16'h00F0);
        push(acc_edge(rel), 16'h00F0, 16'h00F0);
        drain("pre_reset_drain");
        bus.iComRaw = 16'h00F2;
        repeat (8) @(negedge clk);
        chk("pre_reset_com", {16'h0, bus.oCom}, 32'h000000F0);
        iRes = 1'b1;
        @(negedge clk);
        iRes = 1'b0;
        chk("midreset_com", {16'h0, bus.oCom}, 32'h0);
        chk("midreset_change", {31'h0, bus.oChange}, 32'h0);
        rel = edge_no + 1;
        push(rel + 12, 16'h00F2, 16'h00F2);
        drain("post_reset_drain");

        // 6: bit 2 high for exactly three ticks
        do_reset(16'h0000);
        repeat (2) @(negedge clk);
        bus.iComRaw = 16'h0004;
        push(rel + 12, 16'h0004, 16'h0004);
`ifdef COM_FILTER_STRETCH_EN
        push(rel + 12 + (HT + 1) * SD, 16'h0000, 16'h0004);
`else
        push(rel + 12 + DC * SD, 16'h0000, 16'h0004);
`endif
        repeat (12) @(negedge clk);
        bus.iComRaw = 16'h0000;
        drain("stretch_drain");

        repeat (20) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        chk("final_com", {16'h0, bus.oCom}, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
